keypad_matrix_scanner: RTL and testbench

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

---
 rtl/keypad_matrix_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - debounced single-key matrix keypad scanner with multi-key lockout
// Optional held-key auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 20,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int REPEAT_DLY   = 5000,
    parameter int REPEAT_PER   = 1000,
`endif
    parameter int KW           = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [ROWS-1:0] row_d,
    output logic [COLS-1:0] col_q,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic            key_held
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
`else
    localparam int RPT_MAX = 0;
`endif
    localparam int BASE_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int CNT_MAX  = (BASE_MAX > RPT_MAX) ? BASE_MAX : RPT_MAX;
    localparam int CNTW     = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYC - 1);
    localparam logic [CNTW-1:0] DEB_LAST    = CNTW'(DEBOUNCE_CYC - 1);
    localparam logic [CNTW-1:0] CNT_SAT     = {CNTW{1'b1}};
    localparam logic [CW-1:0]   COL_LAST    = CW'(COLS - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t          r_state, w_state_nxt;
    logic [ROWS-1:0] r_sync1, r_sync2;
    logic [CW-1:0]   r_col, w_col_nxt, r_col_d1, r_col_d2;
    logic [RW-1:0]   r_row, w_row_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic            r_valid, w_valid_nxt;
    logic [KW-1:0]   r_code, w_code_nxt;

    logic [ROWS-1:0] w_rs;
    logic            w_low_any;
    logic [RW-1:0]   w_low_idx;
    logic [CW-1:0]   w_col_inc;
    logic [CNTW-1:0] w_cnt_inc;
    logic            w_aligned;
    logic            w_key_up;
    logic [KW-1:0]   w_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNTW-1:0] RPT_DLY_LAST = CNTW'(REPEAT_DLY - 1);
    localparam logic [CNTW-1:0] RPT_PER_LAST = CNTW'(REPEAT_PER - 1);
    logic [CNTW-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
    logic            r_rpt_first, w_rpt_first_nxt;
    logic [CNTW-1:0] w_rpt_inc;
    assign w_rpt_inc = (r_rpt_cnt == CNT_SAT) ? r_rpt_cnt : r_rpt_cnt + 1'b1;
`endif

    assign w_rs      = r_sync2;
    assign w_low_any = ~&w_rs;
    assign w_col_inc = (r_col == COL_LAST) ? '0 : r_col + 1'b1;
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    assign w_key_up  = w_rs[r_row];
    assign w_code    = KW'(r_row) * KW'(COLS) + KW'(r_col);
    // rs lags col_q by the synchronizer depth; r_col_d2 names the column rs reflects.
    assign w_aligned = (r_col_d2 == r_col);

    always_comb begin
        w_low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!w_rs[i]) w_low_idx = RW'(i);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_col_d1 <= '0;
            r_col_d2 <= '0;
            r_state  <= SCAN;
            r_col    <= '0;
            r_row    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_code   <= '0;
        end else begin
            r_sync1  <= row_d;
            r_sync2  <= r_sync1;
            r_col_d1 <= r_col;
            r_col_d2 <= r_col_d1;
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_code   <= w_code_nxt;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_first <= w_rpt_first_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_code_nxt  = r_code;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_rpt_first_nxt = r_rpt_first;
`endif
        case (r_state)
            SCAN: begin
                if (r_cnt >= SETTLE_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_low_any) begin
                        w_row_nxt   = w_low_idx;
                        w_col_nxt   = r_col_d2;
                        w_state_nxt = PRESS_DB;
                    end else begin
                        w_col_nxt = w_col_inc;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            PRESS_DB: begin
                if (w_aligned) begin
                    if (w_key_up) begin
                        w_col_nxt   = w_col_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SCAN;
                    end else if (r_cnt >= DEB_LAST) begin
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = w_code;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rpt_cnt_nxt   = '0;
                        w_rpt_first_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            HELD: begin
                if (w_aligned && w_key_up) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = REL_DB;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (r_rpt_cnt >= (r_rpt_first ? RPT_DLY_LAST : RPT_PER_LAST)) begin
                    w_rpt_cnt_nxt   = '0;
                    w_rpt_first_nxt = 1'b0;
                    w_valid_nxt     = ~r_valid;
                end else begin
                    w_rpt_cnt_nxt = w_rpt_inc;
                end
`endif
            end
            REL_DB: begin
                if (w_aligned) begin
                    if (!w_key_up) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rpt_cnt_nxt = '0;
`endif
                    end else if (r_cnt >= DEB_LAST) begin
                        w_col_nxt   = w_col_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SCAN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    assign col_q     = ~(COLS'(1) << r_col);
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_held  = (r_state == HELD) || (r_state == REL_DB);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - randomized self-checking bench for keypad_matrix_scanner
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SETTLE = 2;
    localparam int DEB    = 8;
    localparam int KW     = 4;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [ROWS-1:0] row_d;
    logic [COLS-1:0] col_q;
    logic            key_valid;
    logic            key_held;
    logic [KW-1:0]   key_code;

    logic [ROWS*COLS-1:0] keys = '0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_code[$];
    int pulse_cyc[$];
    logic prev_valid = 1'b0;

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SETTLE), .DEBOUNCE_CYC(DEB),
`ifdef KEYPAD_AUTOREPEAT_EN
        .REPEAT_DLY(40), .REPEAT_PER(10),
`endif
        .KW(KW)
    ) dut (
        .clk(clk), .nrst(nrst), .row_d(row_d), .col_q(col_q),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive keypad: a row reads low while any pressed key in it sits on a driven column.
    always_comb begin
        row_d = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !col_q[c]) row_d[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (nrst) begin
            total++;
            if ($countones(col_q) != COLS - 1) begin
                bad++;
                $display("FAIL col_one_active: col_q=%b required exactly one 0 bit", col_q);
            end
            total++;
            if (prev_valid && key_valid) begin
                bad++;
                $display("FAIL valid_isolated: key_valid high two cycles at cyc %0d, required single-cycle pulses", cyc);
            end
            if (key_valid) begin
                pulse_code.push_back(int'(key_code));
                pulse_cyc.push_back(cyc);
            end
        end
        prev_valid = key_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        keys = '0;
        step(3);
        total++; if (col_q !== 4'b1110) begin bad++; $display("FAIL reset_col_q: got %b required 1110", col_q); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", key_valid); end
        total++; if (key_code !== '0) begin bad++; $display("FAIL reset_code: got %0d required 0", key_code); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b required 0", key_held); end
    endtask

    task automatic test_idle_scan();
        logic [COLS-1:0] exp;
        logic [COLS-1:0] one;
        one = 1;
        nrst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp = ~(one << ((k / SETTLE) % COLS));
            total++;
            if (col_q !== exp) begin bad++; $display("FAIL idle_scan_k%0d: col_q=%b required %b", k, col_q, exp); end
        end
        total++;
        if (pulse_code.size() != 0) begin bad++; $display("FAIL idle_no_pulse: pulses=%0d required 0", pulse_code.size()); end
    endtask

    task automatic test_clean_press();
        int n0;
        int w;
        int exp_code;
        exp_code = 2 * COLS + 1;
        n0 = pulse_code.size();
        keys[2*COLS+1] = 1'b1;
        step(30);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held_pressed: got %b required 1", key_held); end
        keys = '0;
        step(8);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held_release_db: got %b required 1", key_held); end
        w = 0;
        while (key_held && w < 20) begin step(1); w++; end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL clean_held_timeout: got %b required 0", key_held); end
        step(10);
        total++;
        if (pulse_code.size() - n0 != 1) begin bad++; $display("FAIL clean_pulse_count: got %0d required 1", pulse_code.size() - n0); end
        if (pulse_code.size() > n0) begin
            total++;
            if (pulse_code[n0] != exp_code) begin bad++; $display("FAIL clean_pulse_code: got %0d required %0d", pulse_code[n0], exp_code); end
        end
        total++; if (int'(key_code) != exp_code) begin bad++; $display("FAIL clean_code_held: got %0d required %0d", key_code, exp_code); end
    endtask

    task automatic test_bounce();
        int n0;
        int exp_code;
        exp_code = 0 * COLS + 3;
        n0 = pulse_code.size();
        keys[exp_code] = 1'b1; step(3);
        keys = '0;             step(1);
        keys[exp_code] = 1'b1; step(8);
        total++;
        if (pulse_code.size() != n0) begin bad++; $display("FAIL bounce_early_pulse: got %0d pulses required 0", pulse_code.size() - n0); end
        step(12);
        keys = '0;
        step(30);
        total++;
        if (pulse_code.size() - n0 != 1) begin bad++; $display("FAIL bounce_pulse_count: got %0d required 1", pulse_code.size() - n0); end
        if (pulse_code.size() > n0) begin
            total++;
            if (pulse_code[n0] != exp_code) begin bad++; $display("FAIL bounce_code: got %0d required %0d", pulse_code[n0], exp_code); end
        end
    endtask

    task automatic test_lockout();
        int n0;
        int ka;
        int kb;
        ka = 1 * COLS + 0;
        kb = 3 * COLS + 2;
        n0 = pulse_code.size();
        keys[ka] = 1'b1; step(30);
        keys[kb] = 1'b1; step(20);
        keys = '0;       step(40);
        total++;
        if (pulse_code.size() - n0 != 1) begin bad++; $display("FAIL lockout_both_count: got %0d required 1", pulse_code.size() - n0); end
        if (pulse_code.size() > n0) begin
            total++;
            if (pulse_code[n0] != ka) begin bad++; $display("FAIL lockout_both_code: got %0d required %0d", pulse_code[n0], ka); end
        end
        n0 = pulse_code.size();
        keys[ka] = 1'b1; step(30);
        keys[kb] = 1'b1; step(10);
        keys[ka] = 1'b0; step(45);
        keys = '0;       step(40);
        total++;
        if (pulse_code.size() - n0 != 2) begin bad++; $display("FAIL lockout_second_count: got %0d required 2", pulse_code.size() - n0); end
        if (pulse_code.size() >= n0 + 2) begin
            total++;
            if (pulse_code[n0] != ka) begin bad++; $display("FAIL lockout_first_code: got %0d required %0d", pulse_code[n0], ka); end
            total++;
            if (pulse_code[n0+1] != kb) begin bad++; $display("FAIL lockout_second_code: got %0d required %0d", pulse_code[n0+1], kb); end
        end
    endtask

    task automatic test_reset_mid_press();
        int n0;
        nrst = 1'b0;
        keys = '0;
        step(2);
        keys[1*COLS+0] = 1'b1;
        step(1);
        n0 = pulse_code.size();
        nrst = 1'b1;
        step(8);
        nrst = 1'b0;
        keys = '0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            total++; if (col_q !== 4'b1110) begin bad++; $display("FAIL midreset_col_q_%0d: got %b required 1110", k, col_q); end
            total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid_%0d: got %b required 0", k, key_valid); end
            total++; if (key_held !== 1'b0) begin bad++; $display("FAIL midreset_held_%0d: got %b required 0", k, key_held); end
            total++; if (key_code !== '0) begin bad++; $display("FAIL midreset_code_%0d: got %0d required 0", k, key_code); end
        end
        nrst = 1'b1;
        step(1);
        total++; if (col_q !== 4'b1110) begin bad++; $display("FAIL midreset_restart_col: got %b required 1110", col_q); end
        step(30);
        total++;
        if (pulse_code.size() != n0) begin bad++; $display("FAIL midreset_no_pulse: got %0d pulses required 0", pulse_code.size() - n0); end
    endtask

    task automatic test_random();
        int r;
        int c;
        int len;
        int n0;
        int exp_n;
        bit longp;
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            longp = 1'($urandom_range(0, 1));
            len = longp ? $urandom_range(30, 40) : $urandom_range(1, 5);
            exp_n = longp ? 1 : 0;
            n0 = pulse_code.size();
            keys[r*COLS+c] = 1'b1;
            step(len);
            keys = '0;
            step(30);
            total++;
            if (pulse_code.size() - n0 != exp_n) begin
                bad++;
                $display("FAIL random_%0d_count: key %0d len %0d got %0d pulses required %0d", i, r*COLS+c, len, pulse_code.size() - n0, exp_n);
            end
            if (longp && pulse_code.size() > n0) begin
                total++;
                if (pulse_code[n0] != r*COLS+c) begin bad++; $display("FAIL random_%0d_code: got %0d required %0d", i, pulse_code[n0], r*COLS+c); end
            end
            total++;
            if (key_held !== 1'b0) begin bad++; $display("FAIL random_%0d_held: got %b required 0", i, key_held); end
        end
    endtask

    task automatic test_autorepeat();
        int n0;
        int np;
        int d;
        int exp_d;
        int kc;
        kc = 1 * COLS + 1;
        n0 = pulse_code.size();
        keys[kc] = 1'b1;
        step(100);
        keys = '0;
        step(40);
        np = pulse_code.size() - n0;
`ifdef KEYPAD_AUTOREPEAT_EN
        total++;
        if (np < 4) begin
            bad++;
            $display("FAIL repeat_count: got %0d pulses required at least 4", np);
        end else begin
            for (int j = 1; j < np; j++) begin
                d = pulse_cyc[n0+j] - pulse_cyc[n0+j-1];
                exp_d = (j == 1) ? 40 : 10;
                total++;
                if (d != exp_d) begin bad++; $display("FAIL repeat_gap_%0d: got %0d cycles required %0d", j, d, exp_d); end
            end
        end
`else
        total++;
        if (np != 1) begin bad++; $display("FAIL single_pulse_count: got %0d required 1", np); end
`endif
        for (int j = 0; j < np; j++) begin
            total++;
            if (pulse_code[n0+j] != kc) begin bad++; $display("FAIL repeat_code_%0d: got %0d required %0d", j, pulse_code[n0+j], kc); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_lockout();
        test_reset_mid_press();
        test_random();
        test_autorepeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
